// File: rtl/mil_tx_stream.sv
// Purpose: MIL-STD-1553 Manchester-II word transmitter with a word FIFO and bus request/grant.
// Latency: a word starts one clock after the IDLE cycle that sees FIFO non-empty and grant;
//          each word lasts 40*CLK_PER_HALFBIT clocks.
// Backpressure: push_ready drops while the FIFO is full; a push while full is dropped.
// Ports:
//   clk, rst         system clock, async active-high reset
//   push_*           word input: push_sync 0 = command/status sync, 1 = data sync
//   tx_request/grant bus arbitration handshake
//   mil_p/mil_n      differential Manchester line pair (both 0 when idle)
//   tx_busy          word or inter-message gap in progress
//   fifo_level       words currently buffered
//   word_done        one-cycle pulse after each word's parity bit
module mil_tx_stream #(
  parameter int CLK_PER_HALFBIT = 25,
  parameter int FIFO_DEPTH      = 8,
  parameter int GAP_HALFBITS    = 8,
  parameter bit ODD_PARITY      = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_valid,
  output logic                          push_ready,
  input  logic                          push_sync,
  input  logic [15:0]                   push_data,
  output logic                          tx_request,
  input  logic                          tx_grant,
  output logic                          mil_p,
  output logic                          mil_n,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          word_done
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int DW  = $clog2(CLK_PER_HALFBIT);
  localparam int HBW = ($clog2(GAP_HALFBITS + 1) > 6) ? $clog2(GAP_HALFBITS + 1) : 6;

  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_PER_HALFBIT - 1);
  localparam logic [HBW-1:0] GAP_LAST = HBW'((GAP_HALFBITS > 0) ? GAP_HALFBITS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_PARITY,
    S_GAP
  } state_t;

  state_t r_state, w_state_nxt;

  // FIFO storage: bit 16 holds the sync type, bits 15:0 the payload.
  logic [16:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]  r_level;

  logic [DW-1:0]  r_div;
  logic [HBW-1:0] r_hb;       // half-bit index within the current state
  logic [15:0]    r_shift;    // MSB is the data bit being sent
  logic           r_sync;
  logic           r_par;
  logic           r_word_done;
  logic           r_tx_request;

  logic           w_push, w_pop, w_nempty, w_hb_end;
  logic           w_hb_clr, w_hb_inc, w_shift, w_done;
  logic [16:0]    w_head;
  logic           w_head_par;
  logic           w_active, w_lvl;

  assign w_nempty   = (r_level != '0);
  assign push_ready = (r_level != LW'(FIFO_DEPTH));
  assign w_push     = push_valid && push_ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_par = ODD_PARITY ? ~(^w_head[15:0]) : (^w_head[15:0]);
  assign w_hb_end   = (r_div == DIV_LAST);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_hb_clr    = 1'b0;
    w_hb_inc    = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_nempty && tx_grant) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SYNC;
        end
      end
      S_SYNC: begin
        if (w_hb_end) begin
          if (r_hb == HBW'(5)) begin
            w_hb_clr    = 1'b1;
            w_state_nxt = S_DATA;
          end else begin
            w_hb_inc = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_hb_end) begin
          w_shift = r_hb[0];
          if (r_hb == HBW'(31)) begin
            w_hb_clr    = 1'b1;
            w_state_nxt = S_PARITY;
          end else begin
            w_hb_inc = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_hb_end) begin
          if (r_hb == HBW'(1)) begin
            w_done   = 1'b1;
            w_hb_clr = 1'b1;
            // Back-to-back words form one contiguous message; otherwise force a gap.
            if (w_nempty && tx_grant) begin
              w_pop       = 1'b1;
              w_state_nxt = S_SYNC;
            end else if (GAP_HALFBITS > 0) begin
              w_state_nxt = S_GAP;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_hb_inc = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (w_hb_end) begin
          if (r_hb == GAP_LAST) begin
            w_hb_clr    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_hb_inc = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FIFO ----------------
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {push_sync, push_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // ---------------- Bit timing and shift register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div        <= '0;
      r_hb         <= '0;
      r_shift      <= '0;
      r_sync       <= 1'b0;
      r_par        <= 1'b0;
      r_word_done  <= 1'b0;
      r_tx_request <= 1'b0;
    end else begin
      r_word_done  <= w_done;
      r_tx_request <= w_nempty;

      // Divider parks at 0 in IDLE and restarts on every word load.
      if (r_state == S_IDLE || w_pop || w_hb_end) r_div <= '0;
      else                                       r_div <= r_div + DW'(1);

      if (w_pop || w_hb_clr) r_hb <= '0;
      else if (w_hb_inc)     r_hb <= r_hb + HBW'(1);

      if (w_pop) begin
        r_shift <= w_head[15:0];
        r_sync  <= w_head[16];
        r_par   <= w_head_par;
      end else if (w_shift) begin
        r_shift <= {r_shift[14:0], 1'b0};
      end
    end
  end

  // ---------------- Line encoding ----------------
  // First half-bit carries the bit value, second its complement.
  always_comb begin
    w_active = 1'b0;
    w_lvl    = 1'b0;
    case (r_state)
      S_SYNC: begin
        w_active = 1'b1;
        w_lvl    = (r_hb < HBW'(3)) ^ r_sync;   // command sync high first, data sync low first
      end
      S_DATA: begin
        w_active = 1'b1;
        w_lvl    = r_shift[15] ^ r_hb[0];
      end
      S_PARITY: begin
        w_active = 1'b1;
        w_lvl    = r_par ^ r_hb[0];
      end
      default: begin
        w_active = 1'b0;
        w_lvl    = 1'b0;
      end
    endcase
  end

  assign mil_p      = w_active & w_lvl;
  assign mil_n      = w_active & ~w_lvl;
  assign tx_busy    = (r_state != S_IDLE);
  assign tx_request = r_tx_request;
  assign fifo_level = r_level;
  assign word_done  = r_word_done;

endmodule

// File: tb/tb_mil_tx_stream.sv
// Directed bench for mil_tx_stream with CLK_PER_HALFBIT=2, FIFO_DEPTH=4, GAP_HALFBITS=4.
module tb_mil_tx_stream;

  localparam int CPH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic        push_sync = 1'b0;
  logic [15:0] push_data = 16'h0000;
  logic        tx_request;
  logic        tx_grant = 1'b0;
  logic        mil_p, mil_n, tx_busy, word_done;
  logic [2:0]  fifo_level;

  int n_assert = 0;
  int n_fail   = 0;

  mil_tx_stream #(
    .CLK_PER_HALFBIT(2),
    .FIFO_DEPTH(4),
    .GAP_HALFBITS(4),
    .ODD_PARITY(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .push_valid(push_valid),
    .push_ready(push_ready),
    .push_sync(push_sync),
    .push_data(push_data),
    .tx_request(tx_request),
    .tx_grant(tx_grant),
    .mil_p(mil_p),
    .mil_n(mil_n),
    .tx_busy(tx_busy),
    .fifo_level(fifo_level),
    .word_done(word_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic s, input logic [15:0] d);
    push_valid = 1'b1;
    push_sync  = s;
    push_data  = d;
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  // Called at the negedge just before the IDLE cycle that sees the grant.
  task automatic start_tx();
    tx_grant = 1'b1;
    chk("pre_start_lines", {30'd0, mil_p, mil_n}, 32'd0);
    @(negedge clk);
  endtask

  // Checks every clock of one word starting at the current negedge; returns at the
  // negedge of the first clock after the word. Grant is dropped at half-bit drop_hb.
  task automatic check_word(input logic s, input logic [15:0] d, input logic par, input int drop_hb);
    logic lvl;
    logic b;
    int   idx;
    for (int hb = 0; hb < 40; hb++) begin
      if (hb < 6) begin
        lvl = (hb < 3) ? ~s : s;
      end else if (hb < 38) begin
        idx = 15 - ((hb - 6) / 2);
        b   = d[idx];
        lvl = (hb % 2 == 1) ? ~b : b;
      end else begin
        lvl = (hb % 2 == 1) ? ~par : par;
      end
      for (int c = 0; c < CPH; c++) begin
        if (hb == drop_hb && c == 0) tx_grant = 1'b0;
        chk($sformatf("line w%04h hb%0d c%0d", d, hb, c), {30'd0, mil_p, mil_n}, {30'd0, lvl, ~lvl});
        if (hb == 20 && c == 0) chk($sformatf("busy w%04h", d), {31'd0, tx_busy}, 32'd1);
        @(negedge clk);
      end
    end
  endtask

  // Called at the first clock after the final word of a message.
  task automatic check_gap();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("gap_lines k%0d", k), {30'd0, mil_p, mil_n}, 32'd0);
      chk($sformatf("gap_busy k%0d", k), {31'd0, tx_busy}, 32'd1);
      if (k == 1) chk("done_single_cycle", {31'd0, word_done}, 32'd0);
      @(negedge clk);
    end
    chk("idle_after_gap_busy", {31'd0, tx_busy}, 32'd0);
    chk("idle_after_gap_lines", {30'd0, mil_p, mil_n}, 32'd0);
  endtask

  initial begin
    // ---- Reset and idle ----
    @(negedge clk);
    chk("rst_lines", {30'd0, mil_p, mil_n}, 32'd0);
    chk("rst_ready", {31'd0, push_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("idle_lines", {30'd0, mil_p, mil_n}, 32'd0);
    chk("idle_ready", {31'd0, push_ready}, 32'd1);
    chk("idle_req", {31'd0, tx_request}, 32'd0);
    chk("idle_level", {29'd0, fifo_level}, 32'd0);
    chk("idle_busy", {31'd0, tx_busy}, 32'd0);
    chk("idle_done", {31'd0, word_done}, 32'd0);

    // ---- Single WSERV word, grant withheld then given ----
    push_one(1'b0, 16'h02A1);
    repeat (2) @(negedge clk);
    chk("t2_req", {31'd0, tx_request}, 32'd1);
    chk("t2_level", {29'd0, fifo_level}, 32'd1);
    chk("t2_lines_nogrant", {30'd0, mil_p, mil_n}, 32'd0);
    chk("t2_busy_nogrant", {31'd0, tx_busy}, 32'd0);
    start_tx();
    check_word(1'b0, 16'h02A1, 1'b1, -1);
    chk("t2_done", {31'd0, word_done}, 32'd1);
    check_gap();
    chk("t2_level_end", {29'd0, fifo_level}, 32'd0);
    chk("t2_req_end", {31'd0, tx_request}, 32'd0);

    // ---- Two-word contiguous message ----
    tx_grant = 1'b0;
    push_one(1'b0, 16'h02A1);
    push_one(1'b1, 16'h02A1);
    chk("t3_level", {29'd0, fifo_level}, 32'd2);
    start_tx();
    check_word(1'b0, 16'h02A1, 1'b1, -1);
    chk("t3_done1", {31'd0, word_done}, 32'd1);
    chk("t3_req_held", {31'd0, tx_request}, 32'd1);
    check_word(1'b1, 16'h02A1, 1'b1, -1);
    chk("t3_done2", {31'd0, word_done}, 32'd1);
    check_gap();
    chk("t3_req_end", {31'd0, tx_request}, 32'd0);

    // ---- Overfill: 5 pushes into a 4-deep FIFO ----
    tx_grant   = 1'b0;
    push_valid = 1'b1;
    push_sync = 1'b0; push_data = 16'h1234;
    chk("t4_ready0", {31'd0, push_ready}, 32'd1);
    @(negedge clk);
    push_sync = 1'b1; push_data = 16'hFFFF;
    chk("t4_ready1", {31'd0, push_ready}, 32'd1);
    @(negedge clk);
    push_sync = 1'b1; push_data = 16'h0000;
    chk("t4_ready2", {31'd0, push_ready}, 32'd1);
    @(negedge clk);
    push_sync = 1'b0; push_data = 16'h8001;
    chk("t4_ready3", {31'd0, push_ready}, 32'd1);
    @(negedge clk);
    push_sync = 1'b1; push_data = 16'hDEAD;
    chk("t4_ready_full", {31'd0, push_ready}, 32'd0);
    @(negedge clk);
    push_valid = 1'b0;
    chk("t4_level_full", {29'd0, fifo_level}, 32'd4);
    start_tx();
    check_word(1'b0, 16'h1234, 1'b0, -1);
    chk("t4_done_a", {31'd0, word_done}, 32'd1);
    check_word(1'b1, 16'hFFFF, 1'b1, -1);
    chk("t4_done_b", {31'd0, word_done}, 32'd1);
    check_word(1'b1, 16'h0000, 1'b1, -1);
    chk("t4_done_c", {31'd0, word_done}, 32'd1);
    check_word(1'b0, 16'h8001, 1'b1, -1);
    chk("t4_done_d", {31'd0, word_done}, 32'd1);
    check_gap();
    chk("t4_level_end", {29'd0, fifo_level}, 32'd0);
    repeat (10) @(negedge clk);
    chk("t4_no_fifth_lines", {30'd0, mil_p, mil_n}, 32'd0);
    chk("t4_no_fifth_busy", {31'd0, tx_busy}, 32'd0);

    // ---- Grant dropped at data bit 5 of a 3-word message ----
    tx_grant = 1'b0;
    push_one(1'b0, 16'h00FF);
    push_one(1'b1, 16'h0F0F);
    push_one(1'b1, 16'hAAAA);
    start_tx();
    check_word(1'b0, 16'h00FF, 1'b1, 16);
    chk("t5_done", {31'd0, word_done}, 32'd1);
    check_gap();
    repeat (10) @(negedge clk);
    chk("t5_level", {29'd0, fifo_level}, 32'd2);
    chk("t5_req", {31'd0, tx_request}, 32'd1);
    chk("t5_lines_idle", {30'd0, mil_p, mil_n}, 32'd0);

    // ---- Reset 30 clocks into a word ----
    start_tx();
    repeat (30) @(negedge clk);
    chk("t6_mid_active", {31'd0, mil_p ^ mil_n}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_lines", {30'd0, mil_p, mil_n}, 32'd0);
    chk("t6_rst_level", {29'd0, fifo_level}, 32'd0);
    chk("t6_rst_busy", {31'd0, tx_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k % 10 == 0) chk($sformatf("t6_quiet k%0d", k), {30'd0, mil_p, mil_n}, 32'd0);
    end
    chk("t6_req", {31'd0, tx_request}, 32'd0);
    chk("t6_level", {29'd0, fifo_level}, 32'd0);
    chk("t6_busy", {31'd0, tx_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mil_tx_stream.md
Name: mil_tx_stream

Overview:
- Parametrised MIL-STD-1553 word transmitter with an internal word FIFO and a bus-grant handshake.
- Drives one differential Manchester-II output pair from a single system clock.
- Bit timing comes from a parametrised half-bit divider.
- Sits between the SPI-side packet logic (push side) and the bus line driver; the bus arbiter controls it via request/grant.

Parameters:
- CLK_PER_HALFBIT, 25, system clocks per Manchester half-bit (25 at 50 MHz = 1 Mbit/s); minimum 2.
- FIFO_DEPTH, 8, words buffered; power of two, minimum 2.
- GAP_HALFBITS, 8, idle half-bits forced after a message ends (FIFO empty or grant lost) before the next word may start; minimum 0.
- ODD_PARITY, 1, 1 = odd parity per 1553; 0 = even (test mode).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- push_valid  in  1  word offered.
- push_ready  out  1  FIFO not full.
- push_sync  in  1  0 = command/status sync (WSERV), 1 = data sync (WDATA).
- push_data  in  16  word payload, MSB sent first.
- tx_request  out  1  block wants the bus.
- tx_grant  in  1  arbiter grant.
- mil_p  out  1  positive line.
- mil_n  out  1  negative line.
- tx_busy  out  1  word or gap in progress.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words stored.
- word_done  out  1  one-cycle pulse after the parity bit's last half-bit.

Behaviour:
- Reset (async, immediate): mil_p=mil_n=0, FIFO empty, fifo_level=0, push_ready=1, tx_request=0, tx_busy=0, word_done=0, state IDLE, divider=0.
- Push: a word is written when push_valid && push_ready. push_ready=0 when fifo_level==FIFO_DEPTH. A push and a pop in the same cycle leave the level unchanged; a push while full is ignored.
- tx_request = (fifo_level!=0) registered; it stays high through a multi-word message.
- States: IDLE, SYNC, DATA, PARITY, GAP.
- IDLE -> SYNC:
  - Condition: FIFO non-empty and tx_grant sampled high.
  - Same cycle: pop the head into the shift register, compute parity over 16 bits, reset the divider.
  - Next cycle: first half-bit appears on the lines.
- Half-bit strobe: divider counts 0..CLK_PER_HALFBIT-1; each half-bit level holds exactly CLK_PER_HALFBIT clocks.
- SYNC: 6 half-bits.
  - WSERV: 3 high then 3 low.
  - WDATA: 3 low then 3 high.
- DATA: 16 bits, 2 half-bits each.
  - Bit 1 = high then low; bit 0 = low then high.
- PARITY: 1 bit, same encoding. Parity bit makes the total count of ones across the 16 data bits plus the parity bit odd (ODD_PARITY=1) or even.
- "High" means mil_p=1, mil_n=0; "low" is the inverse. Outside words both lines are 0 (idle); mil_p=mil_n=1 never occurs.
- Word = 40 half-bits = 40*CLK_PER_HALFBIT clocks.
- End of PARITY (word_done pulses):
  - FIFO non-empty and tx_grant=1: go straight to SYNC with the next word. No idle half-bit between words (contiguous message).
  - Otherwise: go to GAP, lines 0, for GAP_HALFBITS half-bits, then IDLE. If GAP_HALFBITS=0, go directly to IDLE.
- tx_grant falling mid-word has no effect until the word finishes; that word completes, then GAP. A word is never truncated except by reset.
- tx_busy = 1 in SYNC/DATA/PARITY/GAP.
- Pushes during transmission are accepted normally. A word pushed before the current parity ends joins the message.
- Reset mid-word: lines drop to 0 asynchronously; buffered words are discarded.

Test Plan (CLK_PER_HALFBIT=2, FIFO_DEPTH=4, GAP_HALFBITS=4, ODD_PARITY=1):
- Reset then idle 50 clk -> mil_p=mil_n=0, push_ready=1, tx_request=0, fifo_level=0.
- Push WSERV 16'h02A1 with tx_grant=0 -> tx_request=1, lines stay 0. Raise grant -> 80-clk word:
  - sync p high 6 clk, low 6 clk;
  - bits 0000_0010_1010_0001 Manchester;
  - parity bit 1 (four ones in the data);
  - word_done pulse, then 8 clk gap, then IDLE.
- Push WSERV 16'h02A1 then WDATA 16'h02A1, grant held -> 160 clk contiguous; second sync is low 6 clk / high 6 clk; no idle half-bit between words; a single gap follows.
- Push 5 words back-to-back with grant=0 -> push_ready=0 after the 4th, 5th ignored, fifo_level=4. Grant -> exactly 4 words sent.
- Drop tx_grant at data bit 5 of a 3-word message -> the current word completes with correct parity, then GAP; remaining 2 words wait, fifo_level=2, tx_request=1.
- Assert rst at clk 30 of a word -> lines 0 within the same cycle, fifo_level=0; no further transmission after release.
